nonce_reporter: RTL and testbench

- Sits directly downstream of the hash checker and consumes its registered 33-bit flag+nonce word, where bit 32 is the "hash top word is zero" flag and bits 31:0 are the nonce.
- Captures each winning nonce into a small FIFO.
- Drains the FIFO as 5-byte frames over a byte-wide valid/ready stream that feeds the host UART transmitter.
- Keeps a saturating count of found nonces and a sticky overflow flag.

---
 rtl/nonce_pkg.sv | 29 ++
 rtl/nonce_reporter_if.sv | 33 +++
 rtl/nonce_fifo.sv | 58 +++++
 rtl/nonce_reporter.sv | 124 ++++++++++++
 tb/tb_nonce_reporter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nonce_pkg.sv
// ============================================================================
// Module   : nonce_pkg
// Brief    : Shared widths, frame constants and FSM state type for the reporter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nonce_pkg;

  localparam int NONCE_W  = 32;
  localparam int FLAG_BIT = 32;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [15:0] COUNT_MAX         = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } rpt_state_t;

  // Saturating increment for the found-nonce counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nonce_reporter_if.sv
// ============================================================================
// Module   : nonce_reporter_if
// Brief    : Checker input, UART byte stream and status bundle of the reporter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nonce_reporter_if;
  import nonce_pkg::*;

  logic              chk_valid;
  logic [FLAG_BIT:0] flag_plus_nonce;
  logic              clear;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [15:0]       found_count;
  logic              overflow;
  logic              fifo_empty;

  modport slave (
    input  chk_valid, flag_plus_nonce, clear, tx_ready,
    output tx_data, tx_valid, found_count, overflow, fifo_empty
  );

  modport master (
    output chk_valid, flag_plus_nonce, clear, tx_ready,
    input  tx_data, tx_valid, found_count, overflow, fifo_empty
  );

endinterface

`default_nettype wire

// File: rtl/nonce_fifo.sv
// ============================================================================
// Module   : nonce_fifo
// Brief    : Synchronous FIFO with wrap-bit pointers; caller gates push on full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_fifo
  import nonce_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NONCE_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop = pop && !empty;
  assign rdata    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push)     r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/nonce_reporter.sv
// ============================================================================
// Module   : nonce_reporter
// Brief    : Queues winning nonces and sends them as SYNC+4-byte frames to UART.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_reporter
  import nonce_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  wire logic        clk,
  input  wire logic        rst,
  nonce_reporter_if.slave  bus
);

  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [NONCE_W-1:0] w_head;

  rpt_state_t         r_state;
  logic [NONCE_W-1:0] r_shift;
  logic [1:0]         r_byte_idx;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic [15:0]        r_found_count;
  logic               r_overflow;

  assign w_push_req = bus.chk_valid && bus.flag_plus_nonce[FLAG_BIT];
  assign w_pop      = (r_state == IDLE) && !w_empty && !bus.clear;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop) && !bus.clear;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.clear),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (bus.flag_plus_nonce[NONCE_W-1:0]),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_idx <= 2'd0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (bus.clear) begin
      r_state    <= IDLE;
      r_byte_idx <= 2'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift    <= w_head;
            r_tx_data  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= HDR;
          end
        end
        HDR: begin
          if (bus.tx_ready) begin
            r_tx_data  <= r_shift[NONCE_W-1 -: 8];
            r_byte_idx <= 2'd0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (bus.tx_ready) begin
            r_shift <= {r_shift[NONCE_W-9:0], 8'h00};
            if (r_byte_idx == 2'd3) begin
              r_tx_valid <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tx_data  <= r_shift[NONCE_W-9 -: 8];
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Dropped winners still count; the counter tracks what the checker found.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_found_count <= 16'h0000;
      r_overflow    <= 1'b0;
    end else if (bus.clear) begin
      r_found_count <= 16'h0000;
      r_overflow    <= 1'b0;
    end else if (w_push_req) begin
      r_found_count <= sat_inc16(r_found_count);
      if (w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.found_count = r_found_count;
  assign bus.overflow    = r_overflow;
  assign bus.fifo_empty  = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_nonce_reporter.sv
// ============================================================================
// Module   : tb_nonce_reporter
// Brief    : Directed and random stimulus against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_reporter;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic tb_clk = 1'b0;
  logic rst    = 1'b0;
  always #5 tb_clk = ~tb_clk;

  nonce_reporter_if bus();

  nonce_reporter #(
    .DEPTH     (DEPTH),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending nonces plus the bytes of the frame currently on the wire.
  logic [31:0] m_fifo[$];
  logic [7:0]  m_cur[$];
  logic [15:0] m_count = 16'h0;
  logic        m_ovf   = 1'b0;
  logic [7:0]  cap[$];

  always @(posedge tb_clk or posedge rst) begin : model
    logic [31:0] n;
    if (rst || bus.clear) begin
      m_fifo.delete();
      m_cur.delete();
      m_count = 16'h0;
      m_ovf   = 1'b0;
    end else begin
      if (m_cur.size() == 0) begin
        if (m_fifo.size() != 0) begin
          n = m_fifo.pop_front();
          m_cur.push_back(SYNC);
          m_cur.push_back(n[31:24]);
          m_cur.push_back(n[23:16]);
          m_cur.push_back(n[15:8]);
          m_cur.push_back(n[7:0]);
        end
      end else if (bus.tx_ready) begin
        void'(m_cur.pop_front());
      end
      if (bus.chk_valid && bus.flag_plus_nonce[32]) begin
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(bus.flag_plus_nonce[31:0]);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge tb_clk) begin
    if (!rst) begin
      check("tx_valid", 64'(bus.tx_valid), 64'(m_cur.size() != 0));
      if (m_cur.size() != 0) check("tx_data", 64'(bus.tx_data), 64'(m_cur[0]));
      check("found_count", 64'(bus.found_count), 64'(m_count));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
      check("fifo_empty", 64'(bus.fifo_empty), 64'(m_fifo.size() == 0));
      if (bus.tx_valid && bus.tx_ready) cap.push_back(bus.tx_data);
    end
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push(input logic [32:0] v);
    bus.chk_valid       = 1'b1;
    bus.flag_plus_nonce = v;
    tick();
    bus.chk_valid       = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((m_cur.size() != 0 || m_fifo.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_bound", 64'(m_cur.size() + m_fifo.size()), 64'd0);
    tick();
  endtask

  function automatic logic [39:0] pack5(input int start);
    logic [39:0] r = '0;
    if (cap.size() < start + 5) return 40'h0;
    for (int i = 0; i < 5; i++) r = {r[31:0], cap[start+i]};
    return r;
  endfunction

  initial begin
    logic [39:0] exp_frame;
    int          n;

    bus.chk_valid       = 1'b0;
    bus.flag_plus_nonce = '0;
    bus.clear           = 1'b0;
    bus.tx_ready        = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1 rst = 1'b0;

    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'h00);
    check("rst_found", 64'(bus.found_count), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_empty", 64'(bus.fifo_empty), 64'd1);

    // Flag clear: no effect.
    push(33'h0_00000AAA);
    tick(); tick();
    check("noflag_found", 64'(bus.found_count), 64'd0);
    check("noflag_empty", 64'(bus.fifo_empty), 64'd1);
    check("noflag_valid", 64'(bus.tx_valid), 64'd0);

    // Single winner with ready high.
    bus.tx_ready = 1'b1;
    cap.delete();
    push(33'h1_00000FFF);
    check("lat_edge1_valid", 64'(bus.tx_valid), 64'd0);
    tick();
    check("lat_edge2_valid", 64'(bus.tx_valid), 64'd1);
    check("lat_edge2_data", 64'(bus.tx_data), 64'hA5);
    wait_drain(20);
    check("single_len", 64'(cap.size()), 64'd5);
    check("single_frame", 64'(pack5(0)), 64'hA5_00_00_0F_FF);
    check("single_found", 64'(bus.found_count), 64'd1);
    check("single_empty", 64'(bus.fifo_empty), 64'd1);

    // Backpressure: five stalled cycles at every byte.
    bus.tx_ready = 1'b0;
    cap.delete();
    exp_frame = 40'hA5_DE_AD_BE_EF;
    push(33'h1_DEADBEEF);
    tick();
    for (int b = 0; b < 5; b++) begin
      repeat (5) begin
        tick();
        check("stall_valid", 64'(bus.tx_valid), 64'd1);
        check("stall_data", 64'(bus.tx_data), 64'(exp_frame[39-8*b -: 8]));
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
    tick();
    check("bp_len", 64'(cap.size()), 64'd5);
    check("bp_frame", 64'(pack5(0)), 64'(exp_frame));

    // Overflow: six winners into a stalled reporter.
    do_clear();
    for (int i = 1; i <= 6; i++) push({1'b1, 32'(i)});
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    check("ovf_found", 64'(bus.found_count), 64'd6);
    cap.delete();
    bus.tx_ready = 1'b1;
    wait_drain(60);
    check("ovf_len", 64'(cap.size()), 64'd25);
    for (int k = 0; k < 5; k++)
      check("ovf_frame", 64'(pack5(5*k)), 64'({8'hA5, 32'(k+1)}));

    // Push on the same edge that pops a full FIFO.
    do_clear();
    bus.tx_ready = 1'b0;
    for (int i = 11; i <= 15; i++) push({1'b1, 32'(i)});
    cap.delete();
    bus.tx_ready = 1'b1;
    n = 0;
    while (!(m_cur.size() == 0 && m_fifo.size() == DEPTH) && n < 20) begin
      tick();
      n++;
    end
    check("fullpop_reached", 64'(n < 20), 64'd1);
    push(33'h1_00000010);
    check("fullpop_ovf", 64'(bus.overflow), 64'd0);
    check("fullpop_found", 64'(bus.found_count), 64'd6);
    wait_drain(80);
    check("fullpop_len", 64'(cap.size()), 64'd30);
    check("fullpop_last", 64'(pack5(25)), 64'hA5_00_00_00_10);

    // Clear right after byte DE.
    cap.delete();
    push(33'h1_DEADBEEF);
    n = 0;
    while (cap.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    check("clr_reached", 64'(cap.size()), 64'd2);
    do_clear();
    check("clr_valid", 64'(bus.tx_valid), 64'd0);
    check("clr_empty", 64'(bus.fifo_empty), 64'd1);
    check("clr_found", 64'(bus.found_count), 64'd0);
    check("clr_ovf", 64'(bus.overflow), 64'd0);

    // Asynchronous reset mid-frame with an entry still queued.
    push(33'h1_CAFEF00D);
    push(33'h1_12345678);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.tx_valid), 64'd0);
    check("arst_empty", 64'(bus.fifo_empty), 64'd1);
    repeat (2) @(posedge tb_clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check("post_rst_valid", 64'(bus.tx_valid), 64'd0);
    check("post_rst_empty", 64'(bus.fifo_empty), 64'd1);
    check("post_rst_found", 64'(bus.found_count), 64'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.chk_valid       = ($urandom_range(0, 99) < 30);
      bus.flag_plus_nonce = {1'($urandom_range(0, 1)), 32'($urandom())};
      bus.tx_ready        = ($urandom_range(0, 99) < 70);
      bus.clear           = ($urandom_range(0, 399) == 0);
      tick();
    end
    bus.chk_valid = 1'b0;
    bus.clear     = 1'b0;
    bus.tx_ready  = 1'b1;
    wait_drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
